// File: rtl/rotate_cmd_pkg.sv
// Shared types and constants for the rotate command path.
// Reused by the rotator bench and the downstream consumer.
package rotate_cmd_pkg;

  localparam int ROT_W     = 32;
  localparam int SHIFT_W   = 5;
  localparam int TAG_W_DEF = 4;

  typedef struct packed {
    logic [ROT_W-1:0]     data;
    logic [SHIFT_W-1:0]   shift;
    logic                 left;
    logic [TAG_W_DEF-1:0] tag;
  } rotCmd_t;

  // A zero shift bypasses the rotator, whose shift-by-32 behaviour is not trusted.
  function automatic logic [ROT_W-1:0] pickResult(
    input logic [ROT_W-1:0]   headData,
    input logic [SHIFT_W-1:0] headShift,
    input logic [ROT_W-1:0]   rotResult
  );
    return (headShift == '0) ? headData : rotResult;
  endfunction

endpackage

// File: rtl/rotate_cmd_fifo.sv
// Small register-based FIFO with a combinational head view.
// Pointers wrap naturally (DEPTH is a power of two); level separates full from empty.
module rotate_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [LVL_W-1:0] levelReg;
  logic             doPush;
  logic             doPop;

  assign full    = (levelReg == LVL_W'(DEPTH));
  assign empty   = (levelReg == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign level   = levelReg;
  assign popData = mem[rdPtrReg];

  // Storage is reset so the head view is never X, even before the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doPush && !flush) begin
      mem[wrPtrReg] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      levelReg <= '0;
    end else if (flush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      levelReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
      if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
      case ({doPush, doPop})
        2'b10:   levelReg <= levelReg + 1'b1;
        2'b01:   levelReg <= levelReg - 1'b1;
        default: levelReg <= levelReg;
      endcase
    end
  end

endmodule

// File: rtl/rotate_cmd_stage.sv
// Issue stage ahead of the 32-bit combinational rotator: queues commands,
// drives the rotator from the queue head and registers the result with back-pressure.
module rotate_cmd_stage
  import rotate_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic [5:0]         in_amt,
  input  logic               in_left,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic [31:0]        rot_data,
  output logic [4:0]         rot_shift,
  output logic               rot_left,
  input  logic [31:0]        rot_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic [LVL_W-1:0]   fifo_level,
  output logic [CNT_W-1:0]   done_count
);

  localparam int PAY_W = ROT_W + SHIFT_W + 1 + TAG_W;

  logic [PAY_W-1:0] pushPayload;
  logic [PAY_W-1:0] headPayload;
  logic [TAG_W-1:0] headTag;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pushEn;
  logic             popEn;
  logic             outFire;
  logic             unusedAmtMsb;
  logic             outValidReg;
  logic [31:0]      outDataReg;
  logic [TAG_W-1:0] outTagReg;
  logic [CNT_W-1:0] doneCountReg;

  // Only the low five amount bits matter: rotation is modulo 32.
  assign unusedAmtMsb = in_amt[5];
  assign pushPayload  = {in_data, in_amt[SHIFT_W-1:0], in_left, in_tag};
  assign {rot_data, rot_shift, rot_left, headTag} = headPayload;

  assign in_ready = !fifoFull;
  assign outFire  = outValidReg && out_ready;
  assign pushEn   = in_valid && !fifoFull && !flush;
  assign popEn    = !fifoEmpty && (!outValidReg || out_ready) && !flush;

  rotate_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAY_W)
  ) cmdFifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (pushEn),
    .pushData (pushPayload),
    .pop      (popEn),
    .popData  (headPayload),
    .level    (fifo_level),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValidReg <= 1'b0;
      outDataReg  <= '0;
      outTagReg   <= '0;
    end else if (flush) begin
      outValidReg <= 1'b0;
    end else if (popEn) begin
      outValidReg <= 1'b1;
      outDataReg  <= pickResult(rot_data, rot_shift, rot_result);
      outTagReg   <= headTag;
    end else if (outFire) begin
      outValidReg <= 1'b0;
    end
  end

  // A handshake coinciding with flush is discarded and therefore not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      doneCountReg <= '0;
    end else if (outFire && !flush) begin
      doneCountReg <= doneCountReg + 1'b1;
    end
  end

  assign out_valid  = outValidReg;
  assign out_data   = outDataReg;
  assign out_tag    = outTagReg;
  assign done_count = doneCountReg;

endmodule

// File: tb/tb_rotate_cmd_stage.sv
// Directed bench for rotate_cmd_stage with a stand-in rotator that
// deliberately returns garbage for a zero shift so the bypass is exercised.
module tb_rotate_cmd_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_amt;
  logic        in_left;
  logic [3:0]  in_tag;
  logic        flush;
  logic [31:0] rot_data;
  logic [4:0]  rot_shift;
  logic        rot_left;
  logic [31:0] rot_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic [2:0]  fifo_level;
  logic [15:0] done_count;

  int checks;
  int errors;
  int expDone;

  rotate_cmd_stage #(.DEPTH(4), .TAG_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_left    (in_left),
    .in_tag     (in_tag),
    .flush      (flush),
    .rot_data   (rot_data),
    .rot_shift  (rot_shift),
    .rot_left   (rot_left),
    .rot_result (rot_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .fifo_level (fifo_level),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotStub(input logic [31:0] d, input logic [4:0] s, input logic l);
    logic [63:0] t;
    if (s == 5'd0) return ~d;
    t = l ? ({d, d} << s) : ({d, d} >> s);
    return l ? t[63:32] : t[31:0];
  endfunction

  assign rot_result = rotStub(rot_data, rot_shift, rot_left);

  // Bitwise reference rotation.
  function automatic logic [31:0] refRot(input logic [31:0] d, input logic [5:0] amt, input logic l);
    logic [31:0] r;
    int s;
    s = amt % 32;
    for (int b = 0; b < 32; b++) begin
      if (l) r[(b + s) % 32] = d[b];
      else   r[b] = d[(b + s) % 32];
    end
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setCmd(input logic [31:0] d, input logic [5:0] a, input logic l, input logic [3:0] t);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_left  = l;
    in_tag   = t;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_data = 0; in_amt = 0; in_left = 0; in_tag = 0;
    flush = 0; out_ready = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (done_count !== 16'd0) begin errors++; $display("FAIL reset_done got %0d want 0", done_count); end
    checks++; if (out_data !== 32'd0 || out_tag !== 4'd0) begin errors++; $display("FAIL reset_out got %h/%h want 0/0", out_data, out_tag); end
    checks++; if ($isunknown({rot_data, rot_shift, rot_left})) begin errors++; $display("FAIL reset_rot_x got %h %h %b want no X", rot_data, rot_shift, rot_left); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    $display("reset: level=%0d in_ready=%b", fifo_level, in_ready);
  endtask

  task automatic test_left();
    out_ready = 1'b1;
    setCmd(32'h80000001, 6'd1, 1'b1, 4'd3);
    cycle();
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL left_accept got level=%0d valid=%b want 1/0", fifo_level, out_valid); end
    cycle();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h00000003 || out_tag !== 4'd3) begin
      errors++; $display("FAIL left_result got v=%b %h tag=%0d want 1 00000003 3", out_valid, out_data, out_tag); end
    $display("left: data=%h tag=%0d", out_data, out_tag);
    cycle();
    expDone = 1;
    checks++; if (out_valid !== 1'b0 || done_count !== 16'(expDone)) begin
      errors++; $display("FAIL left_done got v=%b cnt=%0d want 0 %0d", out_valid, done_count, expDone); end
  endtask

  task automatic test_right();
    out_ready = 1'b1;
    setCmd(32'h0000000F, 6'd36, 1'b0, 4'd5);
    cycle();
    checks++; if (rot_shift !== 5'd4 || rot_left !== 1'b0) begin errors++; $display("FAIL right_shift got %0d/%b want 4/0", rot_shift, rot_left); end
    setCmd(32'h12345678, 6'd0, 1'b1, 4'd6);
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hF0000000 || out_tag !== 4'd5) begin
      errors++; $display("FAIL right_result got v=%b %h tag=%0d want 1 f0000000 5", out_valid, out_data, out_tag); end
    $display("right: data=%h tag=%0d", out_data, out_tag);
    cycle();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h12345678 || out_tag !== 4'd6) begin
      errors++; $display("FAIL bypass_result got v=%b %h tag=%0d want 1 12345678 6", out_valid, out_data, out_tag); end
    $display("bypass: data=%h tag=%0d", out_data, out_tag);
    cycle();
    expDone = 3;
    checks++; if (out_valid !== 1'b0 || done_count !== 16'(expDone)) begin
      errors++; $display("FAIL right_done got v=%b cnt=%0d want 0 %0d", out_valid, done_count, expDone); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vData [6];
    logic [5:0]  vAmt  [6];
    logic        vLeft [6];
    logic [31:0] vExp  [5];
    int accepted;
    vData = '{32'h80000001, 32'h0000000F, 32'hDEADBEEF, 32'h12345678, 32'h00000001, 32'hAAAAAAAA};
    vAmt  = '{6'd1, 6'd4, 6'd8, 6'd16, 6'd31, 6'd3};
    vLeft = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vExp  = '{32'h00000003, 32'hF0000000, 32'hADBEEFDE, 32'h56781234, 32'h80000000};
    accepted = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      setCmd(vData[i], vAmt[i], vLeft[i], 4'(i + 1));
      if (in_ready === 1'b1) accepted++;
      cycle();
    end
    in_valid = 1'b0;
    checks++; if (accepted != 5) begin errors++; $display("FAIL bp_accepted got %0d want 5", accepted); end
    checks++; if (in_ready !== 1'b0 || fifo_level !== 3'd4 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_full got rdy=%b level=%0d v=%b want 0 4 1", in_ready, fifo_level, out_valid); end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== vExp[j] || out_tag !== 4'(j + 1)) begin
        errors++; $display("FAIL bp_drain%0d got v=%b %h tag=%0d want 1 %h %0d", j, out_valid, out_data, out_tag, vExp[j], j + 1); end
      $display("drain %0d: data=%h tag=%0d", j, out_data, out_tag);
      cycle();
    end
    expDone = 8;
    checks++; if (out_valid !== 1'b0 || done_count !== 16'(expDone)) begin
      errors++; $display("FAIL bp_done got v=%b cnt=%0d want 0 %0d", out_valid, done_count, expDone); end
  endtask

  task automatic test_streaming();
    logic [31:0] qData [$];
    logic [3:0]  qTag  [$];
    logic [31:0] d;
    logic [5:0]  a;
    logic        l;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = $urandom; a = 6'($urandom_range(0, 63)); l = 1'($urandom_range(0, 1));
      setCmd(d, a, l, 4'(i));
      qData.push_back(refRot(d, a, l));
      qTag.push_back(4'(i));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b want 1", i, in_ready); end
      cycle();
      checks++; if (fifo_level > 3'd1) begin errors++; $display("FAIL stream_level%0d got %0d want <=1", i, fifo_level); end
      if (i >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_data !== qData[0] || out_tag !== qTag[0]) begin
          errors++; $display("FAIL stream%0d got v=%b %h tag=%0d want 1 %h %0d", i - 1, out_valid, out_data, out_tag, qData[0], qTag[0]); end
        $display("stream %0d: data=%h tag=%0d", i - 1, out_data, out_tag);
        void'(qData.pop_front()); void'(qTag.pop_front());
      end
    end
    in_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b1 || out_data !== qData[0] || out_tag !== qTag[0]) begin
      errors++; $display("FAIL stream19 got v=%b %h tag=%0d want 1 %h %0d", out_valid, out_data, out_tag, qData[0], qTag[0]); end
    $display("stream 19: data=%h tag=%0d", out_data, out_tag);
    cycle();
    expDone = 28;
    checks++; if (out_valid !== 1'b0 || done_count !== 16'(expDone)) begin
      errors++; $display("FAIL stream_done got v=%b cnt=%0d want 0 %0d", out_valid, done_count, expDone); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setCmd(32'h01010101 * (i + 1), 6'(i + 2), 1'b1, 4'(i + 10));
      cycle();
    end
    checks++; if (fifo_level !== 3'd3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_setup got level=%0d v=%b want 3 1", fifo_level, out_valid); end
    flush = 1'b1; out_ready = 1'b1;
    setCmd(32'hCAFEF00D, 6'd5, 1'b0, 4'd15);
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0 || done_count !== 16'(expDone)) begin
      errors++; $display("FAIL flush_clear got level=%0d v=%b cnt=%0d want 0 0 %0d", fifo_level, out_valid, done_count, expDone); end
    $display("flush: level=%0d valid=%b count=%0d", fifo_level, out_valid, done_count);
    cycle();
    checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_hold got level=%0d v=%b want 0 0", fifo_level, out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setCmd(32'h00F00F00 + i, 6'd7, 1'b0, 4'(i));
      cycle();
    end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0 || done_count !== 16'd0 || out_data !== 32'd0) begin
      errors++; $display("FAIL areset_now got v=%b level=%0d cnt=%0d data=%h want 0 0 0 0", out_valid, fifo_level, done_count, out_data); end
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || done_count !== 16'd0) begin
      errors++; $display("FAIL areset_release got rdy=%b cnt=%0d want 1 0", in_ready, done_count); end
    setCmd(32'h0000FFFF, 6'd16, 1'b1, 4'd9);
    cycle();
    in_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF0000 || out_tag !== 4'd9) begin
      errors++; $display("FAIL areset_recover got v=%b %h tag=%0d want 1 ffff0000 9", out_valid, out_data, out_tag); end
    $display("after reset: data=%h tag=%0d", out_data, out_tag);
    cycle();
    checks++; if (done_count !== 16'd1) begin errors++; $display("FAIL areset_count got %0d want 1", done_count); end
  endtask

  initial begin
    checks = 0; errors = 0; expDone = 0;
    test_reset();
    test_left();
    test_right();
    test_back_to_back();
    test_streaming();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
